// File: rtl/plic_target_arb.sv
// PLIC per-target arbiter: selects the highest-priority enabled pending
// source, raises the hart interrupt above threshold, and runs the
// claim/complete handshake with the gateways.
module plic_target_arb #(
  parameter int SRC_NUM    = 32,
  parameter int PRIO_WIDTH = 3,
  localparam int IDW       = $clog2(SRC_NUM)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [SRC_NUM-1:0]            ip_i,
  input  logic [SRC_NUM-1:0]            ie_i,
  input  logic [SRC_NUM*PRIO_WIDTH-1:0] prio_i,
  input  logic [PRIO_WIDTH-1:0]         th_i,
  input  logic                          claim_i,
  output logic                          claim_rdy_o,
  output logic                          claim_vld_o,
  output logic [IDW-1:0]                claim_id_o,
  input  logic                          comp_i,
  input  logic [IDW-1:0]                comp_id_i,
  output logic [SRC_NUM-1:0]            gw_claim_o,
  output logic [SRC_NUM-1:0]            gw_comp_o,
  output logic                          irq_o,
  output logic [IDW-1:0]                max_id_o
);

  typedef enum logic [1:0] {IDLE, RESP, SETTLE} state_t;

  state_t                state_q, state_next;
  logic [SRC_NUM-1:0]    claimed_q;
  logic [SRC_NUM-1:0]    cand;
  logic [SRC_NUM-1:0]    set_mask;
  logic [SRC_NUM-1:0]    clr_mask;
  logic [SRC_NUM-1:0]    gw_comp_q;
  logic [PRIO_WIDTH-1:0] prio_arr [SRC_NUM];
  logic [IDW-1:0]        sel_id;
  logic [PRIO_WIDTH-1:0] sel_prio;
  logic [IDW-1:0]        best_id_q;
  logic [PRIO_WIDTH-1:0] best_prio_q;
  logic                  irq_q;
  logic [IDW-1:0]        claim_id_q;
  logic                  unused_ok;

  // Unpack priorities and form the candidate vector; ID 0 is reserved
  // and never competes.
  genvar gi;
  generate
    for (gi = 0; gi < SRC_NUM; gi++) begin : g_src
      assign prio_arr[gi] = prio_i[gi*PRIO_WIDTH +: PRIO_WIDTH];
      if (gi == 0) begin : g_rsvd
        assign cand[gi] = 1'b0;
      end else begin : g_cand
        assign cand[gi] = ip_i[gi] & ie_i[gi] & ~claimed_q[gi] & (prio_arr[gi] != '0);
      end
    end
  endgenerate

  // Highest priority wins; strict compare keeps the lowest ID on ties.
  always_comb begin
    sel_id   = '0;
    sel_prio = '0;
    for (int k = 1; k < SRC_NUM; k++) begin
      if (cand[k] && (prio_arr[k] > sel_prio)) begin
        sel_prio = prio_arr[k];
        sel_id   = IDW'(k);
      end
    end
  end

  // Accepted completion: non-zero, in range, enabled and currently claimed.
  always_comb begin
    clr_mask = '0;
    if (comp_i && (comp_id_i != '0) && (int'(comp_id_i) < SRC_NUM)) begin
      if (ie_i[comp_id_i] && claimed_q[comp_id_i]) begin
        clr_mask[comp_id_i] = 1'b1;
      end
    end
  end

  // Claim set mask for the response cycle; doubles as the gateway pulse.
  always_comb begin
    set_mask = '0;
    if ((state_q == RESP) && (claim_id_q != '0)) begin
      set_mask[claim_id_q] = 1'b1;
    end
  end

  // Claim FSM next state: IDLE -> RESP -> SETTLE -> IDLE.
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (claim_i) state_next = RESP;
      RESP:    state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state and the ID latched when a claim is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      claim_id_q <= '0;
    end else begin
      state_q <= state_next;
      if ((state_q == IDLE) && claim_i) begin
        claim_id_q <= irq_q ? best_id_q : '0;
      end
    end
  end

  // Registered selection and interrupt; equal-to-threshold does not fire.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_id_q   <= '0;
      best_prio_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      best_id_q   <= sel_id;
      best_prio_q <= sel_prio;
      irq_q       <= (sel_prio > th_i);
    end
  end

  // Outstanding set; a same-cycle claim beats a completion on the same ID.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      claimed_q <= '0;
      gw_comp_q <= '0;
    end else begin
      claimed_q <= (claimed_q & ~clr_mask) | set_mask;
      gw_comp_q <= clr_mask;
    end
  end

  assign claim_rdy_o = (state_q == IDLE);
  assign claim_vld_o = (state_q == RESP);
  assign claim_id_o  = claim_id_q;
  assign gw_claim_o  = set_mask;
  assign gw_comp_o   = gw_comp_q;
  assign irq_o       = irq_q;
  assign max_id_o    = best_id_q;

  // Bits that are intentionally never consumed (reserved ID 0, debug prio).
  assign unused_ok = ^{ip_i[0], prio_arr[0], best_prio_q};

endmodule

// File: tb/tb_plic_target_arb.sv
// Bench for plic_target_arb: a behavioural model tracks the outstanding
// set and claim timing and is compared every cycle, plus literal checks.
module tb_plic_target_arb;

  localparam int N   = 20;
  localparam int PW  = 3;
  localparam int IDW = $clog2(N);

  logic              clk;
  logic              rst;
  logic [N-1:0]      ip;
  logic [N-1:0]      ie;
  logic [N*PW-1:0]   prio;
  logic [PW-1:0]     th;
  logic              claim;
  logic              claim_rdy;
  logic              claim_vld;
  logic [IDW-1:0]    claim_id;
  logic              comp;
  logic [IDW-1:0]    comp_id;
  logic [N-1:0]      gw_claim;
  logic [N-1:0]      gw_comp;
  logic              irq;
  logic [IDW-1:0]    max_id;

  int n_cmp = 0;
  int n_err = 0;

  plic_target_arb #(.SRC_NUM(N), .PRIO_WIDTH(PW)) dut (
    .clk_i(clk), .rst_i(rst), .ip_i(ip), .ie_i(ie), .prio_i(prio), .th_i(th),
    .claim_i(claim), .claim_rdy_o(claim_rdy), .claim_vld_o(claim_vld),
    .claim_id_o(claim_id), .comp_i(comp), .comp_id_i(comp_id),
    .gw_claim_o(gw_claim), .gw_comp_o(gw_comp), .irq_o(irq), .max_id_o(max_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [N-1:0] m_claimed;
  bit [N-1:0] m_gwc;
  bit [N-1:0] m_gwd;
  int         m_best;
  bit         m_irq;
  int         m_busy;   // cycles of claim handshake still ahead (2 = responding)
  bit         m_vld;
  int         m_cid;
  bit         m_ok = 1'b0;

  always @(posedge clk) begin
    int bp;
    int bi;
    int p;
    bit [N-1:0] nc;
    if (rst) begin
      m_claimed = '0; m_gwc = '0; m_gwd = '0; m_best = 0; m_irq = 1'b0;
      m_busy = 0; m_vld = 1'b0; m_cid = 0; m_ok = 1'b1;
    end else begin
      bp = 0;
      bi = 0;
      for (int k = 1; k < N; k++) begin
        p = int'(prio[k*PW +: PW]);
        if (ip[k] && ie[k] && !m_claimed[k] && p > bp) begin
          bp = p;
          bi = k;
        end
      end
      nc    = m_claimed;
      m_gwd = '0;
      if (comp && comp_id != 0 && int'(comp_id) < N && ie[comp_id] && m_claimed[comp_id]) begin
        m_gwd[comp_id] = 1'b1;
        nc[comp_id]    = 1'b0;
      end
      m_gwc = '0;
      if (m_busy == 2) begin
        if (m_cid != 0) nc[m_cid] = 1'b1;
        m_vld  = 1'b0;
        m_busy = 1;
      end else if (m_busy == 1) begin
        m_busy = 0;
      end else if (claim) begin
        m_cid = m_irq ? m_best : 0;
        m_vld = 1'b1;
        if (m_cid != 0) m_gwc[m_cid] = 1'b1;
        m_busy = 2;
      end
      m_claimed = nc;
      m_best    = bi;
      m_irq     = (bp > int'(th));
    end
  end

  // Compare every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (m_ok) begin
      cmp("m_irq",      64'(irq),       64'(m_irq));
      cmp("m_max_id",   64'(max_id),    64'(m_best));
      cmp("m_rdy",      64'(claim_rdy), 64'(m_busy == 0));
      cmp("m_vld",      64'(claim_vld), 64'(m_vld));
      cmp("m_claim_id", 64'(claim_id),  64'(m_cid));
      cmp("m_gw_claim", 64'(gw_claim),  64'(m_gwc));
      cmp("m_gw_comp",  64'(gw_comp),   64'(m_gwd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_prio(input int k, input int p);
    prio[k*PW +: PW] = p[PW-1:0];
  endtask

  initial begin
    rst = 1'b1; ip = '0; ie = '0; prio = '0; th = '0;
    claim = 1'b0; comp = 1'b0; comp_id = '0;
    cyc(); cyc();
    cmp("rst_rdy", 64'(claim_rdy), 64'd1);
    cmp("rst_vld", 64'(claim_vld), 64'd0);
    cmp("rst_irq", 64'(irq), 64'd0);
    cmp("rst_claim_id", 64'(claim_id), 64'd0);
    rst = 1'b0;
    cyc();
    cmp("rdy_after_rst", 64'(claim_rdy), 64'd1);

    // Arbitration: tie resolves to the lower ID, higher priority wins.
    ip = N'((1 << 3) | (1 << 5)); ie = ip; set_prio(3, 2); set_prio(5, 2); th = 3'd1;
    cyc();
    cmp("arb_irq", 64'(irq), 64'd1);
    cmp("arb_tie_low_id", 64'(max_id), 64'd3);
    set_prio(5, 4);
    cyc();
    cmp("arb_prio_win", 64'(max_id), 64'd5);

    // Threshold: equal does not interrupt, below does.
    ip = N'(1 << 7); ie = ip; prio = '0; set_prio(7, 3); th = 3'd3;
    cyc();
    cmp("th_equal_no_irq", 64'(irq), 64'd0);
    cmp("th_sel", 64'(max_id), 64'd7);
    th = 3'd2;
    cyc();
    cmp("th_below_irq", 64'(irq), 64'd1);

    // Claim ID 4; claim held through the response must be ignored.
    ip = N'(1 << 4); ie = ip; prio = '0; set_prio(4, 5); th = 3'd0;
    cyc();
    cmp("clm_pre_id", 64'(max_id), 64'd4);
    claim = 1'b1;
    cyc();
    cmp("clm_vld", 64'(claim_vld), 64'd1);
    cmp("clm_id", 64'(claim_id), 64'd4);
    cmp("clm_gw", 64'(gw_claim), 64'(1 << 4));
    cmp("clm_rdy_low1", 64'(claim_rdy), 64'd0);
    cyc();
    claim = 1'b0;
    cmp("clm_rdy_low2", 64'(claim_rdy), 64'd0);
    cmp("clm_id_hold", 64'(claim_id), 64'd4);
    cyc();
    cmp("clm_rdy_back", 64'(claim_rdy), 64'd1);
    cmp("clm_excluded", 64'(max_id), 64'd0);
    cyc();
    cmp("clm_not_queued", 64'(claim_vld), 64'd0);

    // Empty claim.
    claim = 1'b1;
    cyc();
    claim = 1'b0;
    cmp("empty_vld", 64'(claim_vld), 64'd1);
    cmp("empty_id", 64'(claim_id), 64'd0);
    cmp("empty_gw", 64'(gw_claim), 64'd0);
    cyc(); cyc();

    // Complete ID 4, then invalid completions.
    comp = 1'b1; comp_id = 5'd4;
    cyc();
    comp = 1'b0;
    cmp("comp_pulse", 64'(gw_comp), 64'(1 << 4));
    cyc();
    cmp("comp_eligible", 64'(max_id), 64'd4);
    comp = 1'b1; comp_id = 5'd0;
    cyc();
    cmp("comp_id0", 64'(gw_comp), 64'd0);
    comp_id = 5'd9;
    cyc();
    cmp("comp_unclaimed", 64'(gw_comp), 64'd0);
    comp_id = 5'd25;
    cyc();
    comp = 1'b0;
    cmp("comp_out_of_range", 64'(gw_comp), 64'd0);

    // Two IDs outstanding at once.
    ip = N'((1 << 4) | (1 << 6)); ie = ip; set_prio(6, 3);
    cyc();
    claim = 1'b1;
    cyc();
    claim = 1'b0;
    cmp("multi_first", 64'(claim_id), 64'd4);
    cyc(); cyc();
    cmp("multi_next_sel", 64'(max_id), 64'd6);
    claim = 1'b1;
    cyc();
    claim = 1'b0;
    cmp("multi_second", 64'(claim_id), 64'd6);
    cmp("multi_gw", 64'(gw_claim), 64'(1 << 6));
    cyc(); cyc();
    cmp("multi_no_irq", 64'(irq), 64'd0);
    ie = N'(1 << 6); comp = 1'b1; comp_id = 5'd4;
    cyc();
    cmp("comp_ie_off", 64'(gw_comp), 64'd0);
    ie = N'((1 << 4) | (1 << 6)); comp_id = 5'd6;
    cyc();
    cmp("comp_six", 64'(gw_comp), 64'(1 << 6));
    comp_id = 5'd4;
    cyc();
    comp = 1'b0;
    cmp("comp_four", 64'(gw_comp), 64'(1 << 4));
    cyc();
    cmp("both_free", 64'(max_id), 64'd4);

    // Reset in the middle of a response.
    claim = 1'b1;
    cyc();
    claim = 1'b0;
    cmp("rr_resp", 64'(claim_vld), 64'd1);
    rst = 1'b1;
    cyc();
    cmp("rr_vld", 64'(claim_vld), 64'd0);
    cmp("rr_gw", 64'(gw_claim), 64'd0);
    cmp("rr_id", 64'(claim_id), 64'd0);
    cmp("rr_irq", 64'(irq), 64'd0);
    cmp("rr_max", 64'(max_id), 64'd0);
    rst = 1'b0;
    cyc();
    cmp("rr_rdy", 64'(claim_rdy), 64'd1);
    cmp("rr_cleared", 64'(max_id), 64'd4);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
